vc_test_multi_source: RTL
=========================

# vc_test_multi_source

Multi-channel, count-terminated test source with random inter-message delay, used by unit-test harnesses to drive one or more val/rdy input streams of a design under test. Each channel streams its own preloaded message array in order. A per-channel LFSR inserts random idle cycles between messages, so one block exercises both full-throughput and stalled input patterns. Termination uses an explicit per-channel message count rather than X-detection; `done` is therefore robust and deterministic.

## Interface

Parameters:
- `p_msg_nbits`, 1: message width in bits.
- `p_num_msgs`, 1024: message slots per channel.
- `p_num_chans`, 1: number of independent output channels.
- `p_max_delay`, 0: maximum idle cycles between messages. Must be 0 or 2^k-1; 0 means full throughput.
- `p_lfsr_seed`, 16'hACE1: base LFSR seed. Channel i uses `p_lfsr_seed ^ i`; the value must be nonzero for every channel.
- Local `c_cnt_nbits` = $clog2(p_num_msgs+1).

Ports:
- `clk`, in, 1: clock. One clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `num_msgs`, in, p_num_chans*c_cnt_nbits: messages to send per channel. Channel i uses slice [i*c_cnt_nbits +: c_cnt_nbits]. Sampled only while `reset` is high.
- `val`, out, p_num_chans: per-channel message valid.
- `rdy`, in, p_num_chans: per-channel sink ready.
- `msg`, out, p_num_chans*p_msg_nbits: per-channel message. Channel i uses slice [i*p_msg_nbits +: p_msg_nbits].
- `chan_done`, out, p_num_chans: channel has sent all of its messages.
- `done`, out, 1: AND of all `chan_done` bits.

Storage: flat array `m[p_num_chans*p_num_msgs]`, loaded hierarchically by the bench. Channel i, message j is stored at `m[i*p_num_msgs + j]`.

## Operation

Per-channel state: `cnt` (latched count), `index`, delay counter `dly`, 16-bit Fibonacci LFSR (taps 16,14,13,11), and an FSM with states SEND, DELAY, DONE.
- Reset cycle: latch `cnt` from `num_msgs`, clear `index` and `dly`, load the LFSR seed. Next state is DONE if the latched count is 0, otherwise SEND.
- SEND: `val`=1 and `msg` = `m[base+index]`. A transfer (go) occurs when `val` and `rdy` are both high. On go:
  - `index` increments.
  - If `index+1 == cnt`, next state is DONE.
  - Otherwise load `dly` = LFSR[k-1:0]. Next state is DELAY if `dly` != 0, else SEND.
  - Without go: hold state; `msg` stays stable.
- DELAY: `val`=0. `dly` decrements each cycle; when `dly`==1, next state is SEND.
- DONE: `val`=0 and `chan_done`=1. Held until the next reset.
- The LFSR advances every non-reset cycle, regardless of state.
- When `p_max_delay`=0, delay is always 0 and the channel sends back-to-back.
- `msg` is don't-care while `val`=0 but must be driven from `m[base+index]`, with `index` saturating at `cnt`.
- Channels are fully independent. A stall on one channel never affects another.
- Assertions (clocked, when not in reset):
  - `rdy` is not X.
  - Every `num_msgs` slice is ≤ `p_num_msgs`. Checked in the cycle after reset.
- Line trace: each channel shows its val/rdy/msg string, channels joined by `|`.

## Timing

- Reset values of outputs, during the reset cycle and on each cycle reset stays high: `val`=0, `chan_done`=0, `done`=0. `msg` = `m[base+0]`.
- First cycle after reset deasserts:
  - `val[i]`=1 for every channel with a nonzero count.
  - `chan_done[i]`=1 and `val[i]`=0 for every channel with a zero count.
- The first message has zero delay. With `rdy` held high and `p_max_delay`=0, N messages transfer in N consecutive cycles.
- After the final transfer, `chan_done` rises on the next edge. `done` rises in the same cycle as the last `chan_done`.
- Inter-message gap is exactly `dly` cycles of `val`=0, with `dly` in [0, p_max_delay].
- Reset asserted mid-stream takes effect at the next edge:
  - Transfers in progress are abandoned.
  - `index` returns to 0 and `num_msgs` is re-latched.
  - The LFSR reseeds, so delay sequences are reproducible across resets.
- `num_msgs` changes while reset is low have no effect.

## Test plan

- 1 channel, `p_max_delay`=0, count 4, msgs 0x11..0x14, `rdy`=1: `val` is high for 4 consecutive cycles with msgs 0x11, 0x12, 0x13, 0x14. `chan_done` and `done` rise the cycle after the last transfer.
- Same setup, `rdy` low for 3 cycles on the second message: `msg` holds 0x12 with `val`=1 for all 3 cycles. Total transfers is exactly 4, with no duplicates or skips.
- `p_max_delay`=7, count 16, `rdy`=1:
  - Every gap is 0-7 cycles.
  - Message order is preserved.
  - The gap sequence is identical after a second reset with the same seed.
- 3 channels, counts 2/0/5: channel 1 has `chan_done`=1 in the first post-reset cycle; channel 0 finishes before channel 2; `done` rises only after channel 2 completes.
- Reset asserted after 2 of 5 messages, with `num_msgs` changed to 3: the next cycle restarts at message 0, exactly 3 messages are sent, then `done`=1.
- Count equal to `p_num_msgs` (1024): all slots are sent, and `index` does not wrap or send slot 0 again.

Source files
------------

// File: rtl/vc_test_multi_source.sv
// rtl/vc_test_multi_source.sv - multi-channel count-terminated val/rdy test source with random inter-message delay
// Each channel walks its own slice of m[] under a SEND/DELAY/DONE FSM paced by a per-channel LFSR.
module vc_test_multi_source #(
    parameter int          p_msg_nbits = 1,
    parameter int          p_num_msgs  = 1024,
    parameter int          p_num_chans = 1,
    parameter int          p_max_delay = 0,
    parameter logic [15:0] p_lfsr_seed = 16'hACE1,
    localparam int         c_cnt_nbits = $clog2(p_num_msgs + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [p_num_chans*c_cnt_nbits-1:0] num_msgs,
    output logic [p_num_chans-1:0]             val,
    input  logic [p_num_chans-1:0]             rdy,
    output logic [p_num_chans*p_msg_nbits-1:0] msg,
    output logic [p_num_chans-1:0]             chan_done,
    output logic                               done
);

    localparam int c_num_slots  = p_num_chans * p_num_msgs;
    localparam int c_addr_nbits = (c_num_slots > 1) ? $clog2(c_num_slots) : 1;
    localparam int c_dly_nbits  = (p_max_delay > 0) ? $clog2(p_max_delay + 1) : 1;

    localparam logic [c_cnt_nbits-1:0] c_cnt_one  = c_cnt_nbits'(1);
    localparam logic [c_cnt_nbits-1:0] c_last_idx = c_cnt_nbits'(p_num_msgs - 1);
    localparam logic [c_cnt_nbits-1:0] c_max_cnt  = c_cnt_nbits'(p_num_msgs);
    localparam logic [c_dly_nbits-1:0] c_dly_one  = c_dly_nbits'(1);
    // A zero mask forces every delay to 0 when full throughput is requested.
    localparam logic [c_dly_nbits-1:0] c_dly_mask = c_dly_nbits'(p_max_delay);

    typedef enum logic [1:0] {
        ST_SEND  = 2'd0,
        ST_DELAY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Message storage, preloaded hierarchically by the harness.
    logic [p_msg_nbits-1:0] m [c_num_slots];

    logic reset_q;

    always_ff @(posedge clk) begin
        reset_q <= reset;
    end

    assert property (@(posedge clk) disable iff (reset) !$isunknown(rdy))
        else $error("rdy is unknown");

    for (genvar ch = 0; ch < p_num_chans; ch++) begin : g_chan
        localparam logic [15:0]             c_seed = p_lfsr_seed ^ 16'(ch);
        localparam logic [c_addr_nbits-1:0] c_base = c_addr_nbits'(ch * p_num_msgs);

        state_t                  state_q, state_d;
        logic [c_cnt_nbits-1:0]  num_i;
        logic [c_cnt_nbits-1:0]  cnt_q;
        logic [c_cnt_nbits-1:0]  index_q, index_d;
        logic [c_cnt_nbits-1:0]  rd_idx;
        logic [c_addr_nbits-1:0] rd_addr;
        logic [c_dly_nbits-1:0]  dly_q, dly_d, dly_load;
        logic [15:0]             lfsr_q;
        logic                    lfsr_fb;

        assign num_i    = num_msgs[ch*c_cnt_nbits +: c_cnt_nbits];
        assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        assign dly_load = lfsr_q[c_dly_nbits-1:0] & c_dly_mask;

        always_comb begin
            state_d = state_q;
            index_d = index_q;
            dly_d   = dly_q;
            case (state_q)
                ST_SEND: begin
                    if (rdy[ch]) begin
                        index_d = index_q + c_cnt_one;
                        if (index_q + c_cnt_one == cnt_q) begin
                            state_d = ST_DONE;
                        end else begin
                            dly_d   = dly_load;
                            state_d = (dly_load != '0) ? ST_DELAY : ST_SEND;
                        end
                    end
                end
                ST_DELAY: begin
                    dly_d = dly_q - c_dly_one;
                    if (dly_q <= c_dly_one) begin
                        state_d = ST_SEND;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_DONE;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q   <= num_i;
                index_q <= '0;
                dly_q   <= '0;
                lfsr_q  <= c_seed;
                state_q <= (num_i == '0) ? ST_DONE : ST_SEND;
            end else begin
                state_q <= state_d;
                index_q <= index_d;
                dly_q   <= dly_d;
                lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
            end
        end

        always_ff @(posedge clk) begin
            if (!reset && reset_q) begin
                assert (cnt_q <= c_max_cnt)
                    else $error("num_msgs slice exceeds p_num_msgs");
            end
        end

        // index reaches cnt after the last transfer; clamp so the read stays inside the slice.
        always_comb begin
            if (reset) begin
                rd_idx = '0;
            end else if (index_q > c_last_idx) begin
                rd_idx = c_last_idx;
            end else begin
                rd_idx = index_q;
            end
        end

        assign rd_addr = c_base + c_addr_nbits'(rd_idx);

        assign val[ch]                            = !reset && (state_q == ST_SEND);
        assign chan_done[ch]                      = !reset && (state_q == ST_DONE);
        assign msg[ch*p_msg_nbits +: p_msg_nbits] = m[rd_addr];
    end

    assign done = &chan_done;

endmodule
